// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: word width, fetch FSM states
// and the default boot address.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold it, or clear valid.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] pc4_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc4
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;

  // Clearing only drops valid; the payload is don't-care while invalid.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc4_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: pc sequencing, one-entry skid buffer for stalls,
// and redirect draining for flushes that arrive while a read is outstanding.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] branch_target,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc4,
  output logic [15:0]        imm16
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] redirect_q, redirect_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [INSTR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic [INSTR_W-1:0] pc_plus4;
  logic               ifid_load, ifid_clear;
  logic [INSTR_W-1:0] ifid_instr_in, ifid_pc4_in;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_d    = redirect_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4;
    case (state_q)
      ST_FETCH: begin
        if (flush) begin
          if (imem_ack) begin
            pc_d = branch_target;
          end else begin
            redirect_d = branch_target;
            state_d    = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          skid_instr_d = '0;
          skid_pc4_d   = '0;
          pc_d         = branch_target;
          state_d      = ST_FETCH;
        end else if (!stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = skid_instr_q;
          ifid_pc4_in   = skid_pc4_q;
          state_d       = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          redirect_d = branch_target;
        end
        // A flush coinciding with the late ack redirects straight to the newest target.
        if (imem_ack) begin
          pc_d    = flush ? branch_target : redirect_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // Without a stall, a cycle that delivers nothing leaves a bubble in IF/ID.
    ifid_clear = flush | (!stall & !ifid_load);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      redirect_q   <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .clear    (ifid_clear),
    .instr_in (ifid_instr_in),
    .pc4_in   (ifid_pc4_in),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4)
  );

  assign imem_req  = (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign imm16     = if_id_instr[15:0];

endmodule
